// File: rtl/postadder26.sv
// Purpose: converts the 26-bit two's-complement adder sum to sign-magnitude and normalizes it (hidden bit at [FW-1]).
// Latency: 2 + k cycles from accept to out_valid, where k is the number of one-bit normalization shifts (0..FW-1).
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, and no new operand is taken before that.
module postadder26 #(
    parameter int FW = 24,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW+1:0] sum,
    input  logic [EW-1:0] exp_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sign,
    output logic [FW-1:0] frac,
    output logic [EW-1:0] exp_out,
    output logic          zero,
    output logic          overflow,
    output logic          underflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [FW+1:0] sum_q;
    logic [FW+1:0] mag;
    logic [EW:0]   exp_inc;
    logic          exp_sat;
    logic [FW-1:0] frac_shl;
    logic [EW-1:0] exp_dec;
    logic          norm_exit;

    logic          sign_q;
    logic [FW-1:0] frac_q;
    logic [EW-1:0] exp_q;
    logic          zero_q;
    logic          ovf_q;
    logic          unf_q;

    // Magnitude of the latched sum and the candidate exponent/fraction updates.
    always_comb begin
        mag       = sum_q[FW+1] ? (~sum_q + 1'b1) : sum_q;
        exp_inc   = {1'b0, exp_q} + 1'b1;
        // Saturate once the bumped exponent reaches or passes all-ones.
        exp_sat   = exp_inc[EW] | (&exp_inc[EW-1:0]);
        frac_shl  = {frac_q[FW-2:0], 1'b0};
        exp_dec   = exp_q - 1'b1;
        norm_exit = frac_shl[FW-1] | (exp_dec == '0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CONV;
            CONV: begin
                // Only a nonzero, sub-normalized magnitude with exponent headroom needs shifting.
                if (mag == '0 || mag[FW+1] || mag[FW] || mag[FW-1] || exp_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = NORM;
                end
            end
            NORM: if (norm_exit) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Operand capture and result datapath; CONV starts from the latched exponent in exp_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            sign_q <= 1'b0;
            frac_q <= '0;
            exp_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sum_q <= sum;
                        exp_q <= exp_in;
                    end
                end
                CONV: begin
                    sign_q <= sum_q[FW+1];
                    zero_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    unf_q  <= 1'b0;
                    if (mag == '0) begin
                        sign_q <= 1'b0;
                        frac_q <= '0;
                        exp_q  <= '0;
                        zero_q <= 1'b1;
                    end else if (mag[FW+1] || mag[FW]) begin
                        // Adder carry-out: drop the LSB (truncate) and bump the exponent.
                        frac_q <= mag[FW:1];
                        if (exp_sat) begin
                            exp_q <= '1;
                            ovf_q <= 1'b1;
                        end else begin
                            exp_q <= exp_inc[EW-1:0];
                        end
                    end else begin
                        frac_q <= mag[FW-1:0];
                        // Already normalized, or no exponent left to trade for shifts.
                        if (!mag[FW-1] && exp_q == '0) begin
                            unf_q <= 1'b1;
                        end
                    end
                end
                NORM: begin
                    frac_q <= frac_shl;
                    exp_q  <= exp_dec;
                    if (norm_exit && !frac_shl[FW-1]) begin
                        unf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result ports come straight from the held registers.
    always_comb begin
        sign      = sign_q;
        frac      = frac_q;
        exp_out   = exp_q;
        zero      = zero_q;
        overflow  = ovf_q;
        underflow = unf_q;
    end

endmodule

// File: tb/tb_postadder26.sv
// Directed bench for postadder26: hand-computed vectors for conversion, normalization,
// carry/overflow, underflow, backpressure and mid-operation reset.
// Inputs are driven around the falling edge; outputs are sampled on the falling edge.
module tb_postadder26;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] sum;
    logic [7:0]  exp_in;
    logic        out_valid;
    logic        out_ready;
    logic        sign;
    logic [23:0] frac;
    logic [7:0]  exp_out;
    logic        zero;
    logic        overflow;
    logic        underflow;

    int checks   = 0;
    int failures = 0;

    postadder26 #(.FW(24), .EW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
        .frac      (frac),
        .exp_out   (exp_out),
        .zero      (zero),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one operand, measure latency, check the result, then drain it.
    task automatic run_op(input string tag, input logic [25:0] s, input logic [7:0] e,
                          input logic sg, input logic [23:0] fr, input logic [7:0] ex,
                          input logic z, input logic ov, input logic un, input int lat_exp);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        sum      = s;
        exp_in   = e;
        @(posedge clk);
        #1 in_valid = 1'b0;
        sum = '0;
        exp_in = '0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (out_valid || lat > 40) break;
            lat++;
        end
        chk({tag, ".latency"},   lat, lat_exp);
        chk({tag, ".sign"},      {31'd0, sign}, {31'd0, sg});
        chk({tag, ".frac"},      {8'd0, frac}, {8'd0, fr});
        chk({tag, ".exp_out"},   {24'd0, exp_out}, {24'd0, ex});
        chk({tag, ".flags"},     {29'd0, zero, overflow, underflow}, {29'd0, z, ov, un});
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".drained"},   {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        logic [23:0] f_hold;
        logic [7:0]  e_hold;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sum = '0;
        exp_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.hs",    {30'd0, in_ready, out_valid}, 32'd2);
        chk("reset.outs",  {sign, frac, zero, overflow, underflow}, 32'd0);
        chk("reset.exp",   {24'd0, exp_out}, 32'd0);

        run_op("aligned",   26'h0800000, 8'h7F, 1'b0, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0, 2);
        run_op("negative",  26'h3800000, 8'h7F, 1'b1, 24'h800000, 8'h7F, 1'b0, 1'b0, 1'b0, 2);
        run_op("zero",      26'h0000000, 8'h7F, 1'b0, 24'h000000, 8'h00, 1'b1, 1'b0, 1'b0, 2);
        run_op("carry",     26'h1800000, 8'h80, 1'b0, 24'hC00000, 8'h81, 1'b0, 1'b0, 1'b0, 2);
        run_op("overflow",  26'h1000000, 8'hFE, 1'b0, 24'h800000, 8'hFF, 1'b0, 1'b1, 1'b0, 2);
        run_op("fullnorm",  26'h0000001, 8'h7F, 1'b0, 24'h800000, 8'h68, 1'b0, 1'b0, 1'b0, 25);
        run_op("underflow", 26'h0000010, 8'h03, 1'b0, 24'h000080, 8'h00, 1'b0, 1'b0, 1'b1, 5);
        run_op("midnorm",   26'h0001234, 8'h7F, 1'b0, 24'h91A000, 8'h74, 1'b0, 1'b0, 1'b0, 13);
        run_op("negnorm",   26'h3FFFFF0, 8'h7F, 1'b1, 24'h800000, 8'h6C, 1'b0, 1'b0, 1'b0, 21);
        run_op("exp0",      26'h0000010, 8'h00, 1'b0, 24'h000010, 8'h00, 1'b0, 1'b0, 1'b1, 2);

        // Backpressure: hold the result 5 cycles while offering another operand.
        @(negedge clk);
        in_valid = 1'b1;
        sum = 26'h1800000;
        exp_in = 8'h80;
        @(posedge clk);
        #1 sum = 26'h0000001;
        exp_in = 8'h10;
        repeat (2) @(negedge clk);
        chk("bp.valid", {31'd0, out_valid}, 32'd1);
        f_hold = frac;
        e_hold = exp_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.stable", {out_valid, in_ready, frac, exp_out[5:0]},
                {1'b1, 1'b0, 24'hC00000, e_hold[5:0]});
        end
        chk("bp.frac_hold", {8'd0, f_hold}, 32'h00C00000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("bp.one_result", seen, 0);
        end

        // Reset in the middle of normalization.
        @(negedge clk);
        in_valid = 1'b1;
        sum = 26'h0000001;
        exp_in = 8'h7F;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst.busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.hs",   {30'd0, in_ready, out_valid}, 32'd2);
        chk("rst.outs", {sign, frac, zero, overflow, underflow}, 32'd0);
        chk("rst.exp",  {24'd0, exp_out}, 32'd0);

        run_op("after_rst", 26'h0800000, 8'h40, 1'b0, 24'h800000, 8'h40, 1'b0, 1'b0, 1'b0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/postadder26.md
Name: postadder26

Overview:
- Return-path partner of the pre-adder stage; sits between adder26 and exponent/result packing in the FPAU add path.
- Accepts the 26-bit two's-complement sum from adder26 plus the working exponent.
- Converts the sum back to sign-magnitude, then normalizes the magnitude to a 24-bit fraction with hidden bit at [23], adjusting the exponent.
- Iterative: one left shift per cycle, with valid/ready handshakes on both sides.

Parameters:
- FW, 24, fraction width (sum width is FW+2)
- EW, 8, exponent width

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  sum/exp valid
- in_ready  output  1  block can accept a new operand
- sum  input  FW+2  two's-complement sum from adder26
- exp_in  input  EW  working (larger) exponent
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sign  output  1  result sign
- frac  output  FW  normalized magnitude
- exp_out  output  EW  adjusted exponent
- zero  output  1  result is exactly zero
- overflow  output  1  exponent saturated to all-ones
- underflow  output  1  exponent reached 0 before normalization finished

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State goes to IDLE.
  - sign, frac, exp_out, zero, overflow, underflow and out_valid all go to 0.
  - in_ready = 1 the cycle after reset.
  - Reset has priority in every state, including mid-NORM; any in-flight operand is discarded.
- FSM states are IDLE, CONV, NORM and DONE.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: latch sum and exp_in, go to CONV.
- CONV (one cycle):
  - sign_r = sum[25].
  - mag = sign_r ? (~sum + 1) : sum, computed at 26 bits.
  - mag == 0: sign=0, frac=0, exp_out=0, zero=1 -> DONE.
  - mag[24] == 1 (carry out of the adder):
    - frac = mag[24:1] (truncate, no rounding), exp = exp+1.
    - If the result exponent is all-ones: overflow=1 -> DONE.
  - mag[23] == 1: frac = mag[23:0] -> DONE.
  - Otherwise, if exp == 0: frac = mag[23:0], underflow=1 -> DONE.
  - Otherwise -> NORM.
- NORM (one cycle per shift):
  - frac <<= 1 (zero fill), exp -= 1.
  - Exit to DONE when the new frac[23] == 1 or the new exp == 0.
  - underflow = 1 iff the exit happens with the new frac[23] == 0.
  - Maximum of 23 NORM cycles.
- DONE:
  - out_valid = 1; outputs are held stable until out_ready.
  - On out_valid & out_ready -> IDLE. No bypass: the next operand is accepted in IDLE only.
- Latency and throughput:
  - Result appears 2 + k cycles after the accept edge, where k is the number of NORM shifts (0..23).
  - Throughput is one operand per 3 + k cycles when out_ready is held 1.
- Handshake rules:
  - in_ready = 1 only in IDLE.
  - in_valid outside IDLE is ignored.
  - out_ready outside DONE is ignored.
- Flag updates: zero, overflow and underflow are cleared in CONV and valid only while out_valid = 1.
- Magnitude range: the sum magnitude is ≤ 2^25-2 by construction of the pre-adder, so mag[25] is never set. If it is set, it is treated like mag[24].

Test Plan:
- Positive aligned:
  - Stimulus: sum=26'h0800000, exp_in=8'h7F.
  - Response: out_valid 2 cycles after accept; sign=0, frac=24'h800000, exp_out=8'h7F, all flags 0.
- Negative input and zero sum:
  - Stimulus: sum=26'h3800000, exp_in=8'h7F.
  - Response: sign=1, frac=24'h800000, exp_out=8'h7F.
  - Stimulus: sum=0.
  - Response: zero=1, sign=0, frac=0, exp_out=0.
- Carry out and overflow:
  - Stimulus: sum=26'h1800000, exp_in=8'h80.
  - Response: frac=24'hC00000, exp_out=8'h81.
  - Stimulus: sum=26'h1000000, exp_in=8'hFE.
  - Response: exp_out=8'hFF, overflow=1, frac=24'h800000.
- Full normalization:
  - Stimulus: sum=26'h0000001, exp_in=8'h7F.
  - Response: 23 NORM cycles, out_valid 25 cycles after accept; frac=24'h800000, exp_out=8'h68, underflow=0.
- Underflow:
  - Stimulus: sum=26'h0000010, exp_in=8'h03.
  - Response: 3 shifts; frac=24'h000080, exp_out=0, underflow=1.
- Backpressure and reset:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE.
  - Response: outputs stable and in_ready=0 throughout; a new in_valid is ignored; one result is delivered.
  - Stimulus: assert rst during NORM (sum=26'h0000001).
  - Response: next cycle state is IDLE, all outputs 0, in_ready=1.
